io_uart_tx: RTL and testbench

Memory-mapped output peripheral sitting directly downstream of the processor's IO write port. It consumes the processor's IO write strobe and write data, buffers bytes in a small FIFO, and serialises them as 8N1 UART frames on a single TX pin. It exposes a full flag so the processor can stall, and a sticky overflow flag for dropped writes.

---
 rtl/io_pkg.sv | 15 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/io_uart_tx.sv | 149 ++++++++++++++
 tb/tb_io_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the processor IO peripherals.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int IO_DATA_W            = 32;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; pushes when full and pops when empty are ignored.
module sync_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/io_uart_tx.sv
// IO-mapped UART transmitter: buffers processor byte writes and sends them as 8N1 frames.
module io_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 io_w_en,
    input  logic [IO_DATA_W-1:0] io_w_data,
    input  logic                 ovf_clr,
    output logic                 io_full,
    output logic                 ovf,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(UART_DATA_BITS);

    uart_state_t               r_state;
    uart_state_t               w_state_nxt;
    logic [BAUD_W-1:0]         r_baud_cnt;
    logic [BAUD_W-1:0]         w_baud_nxt;
    logic [BIT_W-1:0]          r_bit_cnt;
    logic [BIT_W-1:0]          w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      r_tx;
    logic                      w_tx_nxt;
    logic                      r_ovf;
    logic                      w_pop;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_baud_done;
    logic [UART_DATA_BITS-1:0] w_head;
    logic                      w_unused_data;

    assign w_unused_data = ^io_w_data[IO_DATA_W-1:UART_DATA_BITS];

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (io_w_en),
        .i_pop   (w_pop),
        .i_din   (io_w_data[UART_DATA_BITS-1:0]),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign w_baud_done = (r_baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + 1'b1;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                w_tx_nxt   = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt == BIT_W'(UART_DATA_BITS - 1)) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        // Next bit is shift[1] now, shift[0] after the shift lands.
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (io_w_en && w_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign io_full = w_full;
    assign ovf     = r_ovf;
    assign tx      = r_tx;
    assign tx_busy = (r_state != IDLE);

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: frame-position reference model, UART line decoder and directed plus random stimulus.
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          io_w_en;
    logic [31:0]   io_w_data;
    logic          ovf_clr;
    logic          io_full;
    logic          ovf;
    logic [CW-1:0] fifo_count;
    logic          tx;
    logic          tx_busy;

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_w_en    (io_w_en),
        .io_w_data  (io_w_data),
        .ovf_clr    (ovf_clr),
        .io_full    (io_full),
        .ovf        (ovf),
        .fifo_count (fifo_count),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: byte queue plus position inside the current frame (-1 = idle line).
    logic [7:0] m_q[$];
    int         m_pos = -1;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;
    bit         m_push;
    bit         m_drop;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_pos = -1;
            m_ovf = 1'b0;
        end else begin
            m_push = io_w_en && (m_q.size() < DEPTH);
            m_drop = io_w_en && !m_push;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FRAME) m_pos = -1;
            end else if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_pos = 0;
            end
            if (m_push) m_q.push_back(io_w_data[7:0]);
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic e_tx;
        int   slot;
        if (m_pos < 0) e_tx = 1'b1;
        else begin
            slot = m_pos / CPB;
            if (slot == 0) e_tx = 1'b0;
            else if (slot == 9) e_tx = 1'b1;
            else e_tx = m_cur[slot-1];
        end
        chk("tx", tx, e_tx);
        chk("tx_busy", tx_busy, m_pos >= 0);
        chk("fifo_count", fifo_count, m_q.size());
        chk("io_full", io_full, m_q.size() == DEPTH);
        chk("ovf", ovf, m_ovf);
    end

    // Line decoder: samples mid-bit, independent of the model's timing.
    logic [7:0] dec_q[$];
    int         start_q[$];
    int         busy_q[$];
    bit         d_act = 0;
    bit         prev_tx = 1;
    int         d_off;
    logic [9:0] d_bits;
    int         busy_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            d_act   = 0;
            prev_tx = 1;
        end else begin
            if (!d_act) begin
                if (prev_tx && tx === 1'b0) begin
                    d_act = 1;
                    d_off = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                d_off++;
            end
            if (d_act && (d_off % CPB) == CPB / 2) begin
                d_bits[d_off / CPB] = tx;
                if (d_off / CPB == 9) begin
                    chk("dec_start_bit", d_bits[0], 1'b0);
                    chk("dec_stop_bit", d_bits[9], 1'b1);
                    chk("dec_byte_vs_model", d_bits[8:1], m_cur);
                    dec_q.push_back(d_bits[8:1]);
                    d_act = 0;
                end
            end
            prev_tx = tx;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) busy_run = 0;
        else if (tx_busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin
            busy_q.push_back(busy_run);
            busy_run = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        io_w_en   = 1'b1;
        io_w_data = d;
        step(1);
        io_w_en   = 1'b0;
    endtask

    task automatic clear_logs();
        dec_q.delete();
        start_q.delete();
        busy_q.delete();
    endtask

    task automatic drain(input int maxc, input string nm);
        int n = 0;
        while ((tx_busy !== 1'b0 || fifo_count !== '0) && n < maxc) begin
            step(1);
            n++;
        end
        chk({nm, "_drain_in_time"}, n < maxc, 1'b1);
        step(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_bits;
        rst_n     = 1'b0;
        io_w_en   = 1'b0;
        io_w_data = '0;
        ovf_clr   = 1'b0;
        step(3);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_full", io_full, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Single byte 0xA5: start, LSB-first data, stop.
        clear_logs();
        a5_bits = 10'b1101001010;
        wr(32'hFFFF_FFA5);
        chk("a5_tx_before_start", tx, 1'b1);
        step(1);
        chk("a5_latency_tx_low", tx, 1'b0);
        step(2);
        chk("a5_bit0", tx, a5_bits[0]);
        for (int k = 1; k < 10; k++) begin
            step(CPB);
            chk($sformatf("a5_bit%0d", k), tx, a5_bits[k]);
        end
        drain(200, "a5");
        chk("a5_busy_frames", busy_q.size(), 1);
        chk("a5_busy_len", busy_q[0], 40);
        chk("a5_dec_n", dec_q.size(), 1);
        chk("a5_dec_byte", dec_q[0], 8'hA5);

        // Reset during data bit 3, with a second byte still buffered.
        clear_logs();
        wr(32'h55);
        wr(32'h66);
        step(16);
        rst_n = 1'b0;
        step(1);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", tx_busy, 1'b0);
        chk("midrst_count", fifo_count, 0);
        rst_n = 1'b1;
        step(60);
        chk("midrst_no_frame", dec_q.size(), 0);
        chk("midrst_no_busy", busy_q.size(), 0);
        chk("midrst_tx_idle", tx, 1'b1);

        // Back-to-back queued while a lead frame is on the line.
        clear_logs();
        wr(32'hFF);
        step(2);
        wr(32'h01);
        chk("b2b_count1", fifo_count, 1);
        wr(32'h02);
        chk("b2b_count2", fifo_count, 2);
        wr(32'h03);
        chk("b2b_count3", fifo_count, 3);
        drain(400, "b2b");
        chk("b2b_dec_n", dec_q.size(), 4);
        chk("b2b_dec0", dec_q[0], 8'hFF);
        chk("b2b_dec1", dec_q[1], 8'h01);
        chk("b2b_dec2", dec_q[2], 8'h02);
        chk("b2b_dec3", dec_q[3], 8'h03);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_period%0d", i), start_q[i+1] - start_q[i], 41);

        // Overflow: 10 writes, one pop lands at the second edge, so 0x19 is dropped.
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            wr(32'h10 + i);
            if (i == 8) begin
                chk("ovf_full_at_8", io_full, 1'b1);
                chk("ovf_not_yet", ovf, 1'b0);
            end
            if (i == 9) begin
                chk("ovf_set", ovf, 1'b1);
                chk("ovf_count_held", fifo_count, 8);
            end
        end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 1'b0);
        io_w_en   = 1'b1;
        io_w_data = 32'hEE;
        ovf_clr   = 1'b1;
        step(1);
        io_w_en = 1'b0;
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", ovf, 1'b1);
        chk("ovf_drop_count", fifo_count, 8);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        drain(800, "ovf");
        chk("ovf_dec_n", dec_q.size(), 9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("ovf_dec%0d", i), dec_q[i], 8'h10 + i);

        // Pointer wrap: bursts of 5, wait for empty between bursts.
        clear_logs();
        for (int b = 0; b < 4; b++) begin
            int n;
            for (int i = 0; i < 5; i++) wr(b * 5 + i);
            n = 0;
            while (fifo_count !== '0 && n < 1000) begin
                step(1);
                n++;
            end
            chk($sformatf("wrap_empty%0d", b), n < 1000, 1'b1);
        end
        drain(400, "wrap");
        chk("wrap_dec_n", dec_q.size(), 20);
        for (int i = 0; i < 20; i++)
            chk($sformatf("wrap_dec%0d", i), dec_q[i], i);
        chk("wrap_ovf", ovf, 1'b0);
        chk("wrap_count", fifo_count, 0);

        // Random traffic against the model, including drops, clears and rare resets.
        for (int c = 0; c < 3000; c++) begin
            io_w_en   = ($urandom_range(0, 99) < 8);
            io_w_data = $urandom;
            ovf_clr   = ($urandom_range(0, 99) < 3);
            rst_n     = ($urandom_range(0, 1499) != 0);
            step(1);
        end
        io_w_en = 1'b0;
        ovf_clr = 1'b0;
        rst_n   = 1'b1;
        drain(1000, "rand");
        chk("rand_end_busy", tx_busy, 1'b0);
        chk("rand_end_tx", tx, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
